regfile: RTL and testbench
==========================

// Module: regfile
// PURPOSE
//   General-purpose register file for the 5-stage pipeline.
//   - Serves the decode stage's two read requests (operand 1: rs, operand 2: rt).
//   - Accepts one write per cycle from the write-back stage.
//   - Register $0 is hardwired to zero.
//   - Same-cycle write-to-read bypass, so decode sees a value written back this cycle.
// PARAMETERS
//   DATA_W    32  register width in bits (matches RegBus)
//   ADDR_W    5   register address width in bits (matches RegAddrBus)
//   NUM_REGS  32  number of architectural registers; must equal 2**ADDR_W
// PORTS
//   clk     in   1       clock; all state updates on rising edge
//   rst     in   1       synchronous reset, active-low (0 = reset)
//   we      in   1       write enable from write-back (1 = write)
//   waddr   in   ADDR_W  write register index
//   wdata   in   DATA_W  write data
//   re1     in   1       read-enable, port 1 (decode operand 1)
//   raddr1  in   ADDR_W  read index, port 1
//   rdata1  out  DATA_W  read data, port 1 (combinational)
//   re2     in   1       read-enable, port 2 (decode operand 2)
//   raddr2  in   ADDR_W  read index, port 2
//   rdata2  out  DATA_W  read data, port 2 (combinational)
// BEHAVIOUR
//   Storage:
//   - NUM_REGS x DATA_W flop array; entry 0 is never written.
//   Reset:
//   - rst==0 at a rising clk edge clears all entries to ZeroWord in that cycle.
//   - Writes presented in a reset cycle are discarded.
//   - While rst==0, rdata1 and rdata2 are forced to ZeroWord.
//   Write:
//   - At a rising edge with rst==1, we==1 and waddr!=0: mem[waddr] <= wdata.
//   - waddr==0 is a silent no-op.
//   Read, port n (0-cycle latency, priority order):
//     1. rst==0                               -> 0
//     2. raddr_n==0                           -> 0
//     3. re_n==1 && we==1 && waddr==raddr_n   -> wdata (bypass)
//     4. re_n==1                              -> mem[raddr_n]
//     5. re_n==0                              -> 0
//   Read-port rules:
//   - Bypass uses the live (pre-edge) we/waddr/wdata.
//   - Both ports may address the same register and may both bypass in one cycle.
//   - Reads never modify state; there is no read handshake and no stall.
//   Reset mid-operation:
//   - rst falling during a burst of writes loses every write from that edge on.
//   - The first write honoured is at the first edge with rst==1.
//   Width rules:
//   - No truncation or extension; addresses are exactly ADDR_W bits.
//   - Out-of-range indices are impossible because NUM_REGS == 2**ADDR_W.
// STRUCTURE
//   Shared include (define.v), extended as needed:
//   - RegBus, RegAddrBus, RegNum(32), RegNumLog2(5), ZeroWord, NOPRegAddr,
//     WriteEnable, ReadEnable.
//   - Add RstActive=1'b0 for this block.
//   One sub-module:
//   - regfile_rport: the priority mux above for a single read port.
//   - Instantiated twice; no state of its own.
//   Array write and reset clearing live in regfile itself; one always block on posedge clk.
// TESTING
//   1. Hold rst=0 for 2 cycles with we=1,waddr=5,wdata=32'hDEAD_BEEF
//      -> after release, read r5 (re1=1) = 0; rdata1/2 = 0 throughout reset.
//   2. Write r3=32'h1234_5678, then next cycle re1=1,raddr1=3
//      -> rdata1 = 32'h1234_5678; re1=0 -> rdata1 = 0.
//   3. Same cycle: we=1,waddr=7,wdata=32'hA5A5_0001; re1=re2=1,raddr1=raddr2=7
//      -> both ports = 32'hA5A5_0001 before the edge; mem[7] holds it after.
//   4. Write waddr=0,wdata=32'hFFFF_FFFF, then read r0 on both ports (with and without same-cycle write)
//      -> always 0.
//   5. Write r31=32'h0000_00FF, r1=32'h8000_0000 on consecutive cycles, then read both
//      -> exact values, no cross-corruption (address-decode / wrap check).
//   6. Write r9=32'h1, assert rst=0 for one edge mid-sequence, then read r9
//      -> 0; a write of 32'h2 presented during the reset edge is absent.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the general-purpose register file. These mirror the
// legacy define.v names so the pipeline's other stages can use the same values.
package regfile_pkg;

    localparam int REG_BUS_W     = 32;
    localparam int REG_ADDR_W    = 5;
    localparam int REG_NUM       = 32;
    localparam int REG_NUM_LOG2  = 5;

    localparam logic [REG_BUS_W-1:0]  ZERO_WORD    = '0;
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic READ_ENABLE  = 1'b1;
    localparam logic RST_ACTIVE   = 1'b0;

endpackage

// File: rtl/regfile_rport.sv
// One combinational read port of the register file: applies the reset,
// $0, same-cycle bypass and read-enable rules in priority order.
module regfile_rport
    import regfile_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] mem_rd,
    output logic [DATA_W-1:0] rdata
);

    logic raddr_zero;
    logic hit_wr;

    assign raddr_zero = (raddr == ADDR_W'(0));
    assign hit_wr     = (we == WRITE_ENABLE) && (waddr == raddr);

    always_comb begin
        rdata = '0;
        if (rst == RST_ACTIVE) begin
            rdata = '0;
        end else if (raddr_zero) begin
            rdata = '0;
        end else if (re == READ_ENABLE && hit_wr) begin
            // Decode sees the write-back value in the same cycle it is written.
            rdata = wdata;
        end else if (re == READ_ENABLE) begin
            rdata = mem_rd;
        end
    end

endmodule

// File: rtl/regfile.sv
// General-purpose register file: two combinational read ports with
// write-back bypass, one write port, $0 hardwired to zero.
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W   = REG_BUS_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_REGS = REG_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    localparam int NUM_RPORTS = 2;

    logic [NUM_REGS-1:0][DATA_W-1:0] mem_q;
    logic [NUM_REGS-1:0][DATA_W-1:0] mem_d;

    logic [NUM_RPORTS-1:0]             re_v;
    logic [NUM_RPORTS-1:0][ADDR_W-1:0] raddr_v;
    logic [NUM_RPORTS-1:0][DATA_W-1:0] rdata_v;

    assign re_v    = {re2, re1};
    assign raddr_v = {raddr2, raddr1};
    assign rdata1  = rdata_v[0];
    assign rdata2  = rdata_v[1];

    always_comb begin
        mem_d = mem_q;
        if (rst == RST_ACTIVE) begin
            mem_d = '0;
        end else if (we == WRITE_ENABLE && waddr != ADDR_W'(0)) begin
            mem_d[waddr] = wdata;
        end
        // Entry 0 never holds anything but zero, even before the first reset.
        mem_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rport
        regfile_rport #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_rport (
            .rst    (rst),
            .we     (we),
            .waddr  (waddr),
            .wdata  (wdata),
            .re     (re_v[p]),
            .raddr  (raddr_v[p]),
            .mem_rd (mem_q[raddr_v[p]]),
            .rdata  (rdata_v[p])
        );
    end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus a randomized run
// compared against an array-based reference model.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;

    int total;
    int bad;

    logic [31:0] model [32];
    logic [31:0] exp1;
    logic [31:0] exp2;

    regfile dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .re2    (re2),
        .raddr2 (raddr2),
        .rdata2 (rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference read: what the decode stage should see given the architectural state.
    function automatic logic [31:0] ref_read(input logic re, input logic [4:0] ra);
        if (!rst)                    return 32'h0;
        if (ra == 5'd0)              return 32'h0;
        if (!re)                     return 32'h0;
        if (we && waddr == ra)       return wdata;
        return model[ra];
    endfunction

    task automatic apply(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
        @(negedge clk);
        rst = r; we = w; waddr = wa; wdata = wd;
        re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
        #1;
        exp1 = ref_read(re1, raddr1);
        exp2 = ref_read(re2, raddr2);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (we && waddr != 5'd0) begin
            model[waddr] = wdata;
        end
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            apply(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 5'd5, 1'b1, 5'd5);
            total++;
            if (rdata1 !== 32'h0) begin bad++; $display("FAIL reset_rd1 cyc%0d got=%h want=0", c, rdata1); end
            total++;
            if (rdata2 !== 32'h0) begin bad++; $display("FAIL reset_rd2 cyc%0d got=%h want=0", c, rdata2); end
            tick();
        end
        apply(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd5);
        total++;
        if (rdata1 !== 32'h0) begin bad++; $display("FAIL reset_r5 got=%h want=0", rdata1); end
        tick();
        for (int a = 1; a < 32; a++) begin
            apply(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 1'b1, 5'(32 - a));
            total++;
            if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
                bad++; $display("FAIL reset_clear r%0d got=%h/%h want=0", a, rdata1, rdata2);
            end
            tick();
        end
    endtask

    task automatic test_write_read();
        apply(1'b1, 1'b1, 5'd3, 32'h1234_5678, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        apply(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd3);
        total++;
        if (rdata1 !== 32'h1234_5678) begin bad++; $display("FAIL wr_rd got=%h want=12345678", rdata1); end
        total++;
        if (rdata2 !== 32'h0) begin bad++; $display("FAIL wr_rd_re2off got=%h want=0", rdata2); end
        tick();
        apply(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 1'b1, 5'd3);
        total++;
        if (rdata1 !== 32'h0) begin bad++; $display("FAIL re1_off got=%h want=0", rdata1); end
        total++;
        if (rdata2 !== 32'h1234_5678) begin bad++; $display("FAIL rd2_r3 got=%h want=12345678", rdata2); end
        tick();
    endtask

    task automatic test_bypass();
        apply(1'b1, 1'b1, 5'd7, 32'hA5A5_0001, 1'b1, 5'd7, 1'b1, 5'd7);
        total++;
        if (rdata1 !== 32'hA5A5_0001) begin bad++; $display("FAIL bypass_rd1 got=%h want=a5a50001", rdata1); end
        total++;
        if (rdata2 !== 32'hA5A5_0001) begin bad++; $display("FAIL bypass_rd2 got=%h want=a5a50001", rdata2); end
        tick();
        apply(1'b1, 1'b0, 5'd7, 32'h0, 1'b1, 5'd7, 1'b1, 5'd3);
        total++;
        if (rdata1 !== 32'hA5A5_0001) begin bad++; $display("FAIL bypass_stored got=%h want=a5a50001", rdata1); end
        total++;
        if (rdata2 !== 32'h1234_5678) begin bad++; $display("FAIL bypass_other got=%h want=12345678", rdata2); end
        tick();
        // Bypass must not fire when the write port is idle, even with a matching address.
        apply(1'b1, 1'b0, 5'd3, 32'hFFFF_0000, 1'b1, 5'd3, 1'b0, 5'd3);
        total++;
        if (rdata1 !== 32'h1234_5678) begin bad++; $display("FAIL bypass_we0 got=%h want=12345678", rdata1); end
        tick();
    endtask

    task automatic test_r0();
        apply(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd0);
        total++;
        if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
            bad++; $display("FAIL r0_same_cycle got=%h/%h want=0", rdata1, rdata2);
        end
        tick();
        apply(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0);
        total++;
        if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
            bad++; $display("FAIL r0_after got=%h/%h want=0", rdata1, rdata2);
        end
        tick();
    endtask

    task automatic test_wrap();
        apply(1'b1, 1'b1, 5'd31, 32'h0000_00FF, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        apply(1'b1, 1'b1, 5'd1, 32'h8000_0000, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        apply(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 1'b1, 5'd1);
        total++;
        if (rdata1 !== 32'h0000_00FF) begin bad++; $display("FAIL wrap_r31 got=%h want=000000ff", rdata1); end
        total++;
        if (rdata2 !== 32'h8000_0000) begin bad++; $display("FAIL wrap_r1 got=%h want=80000000", rdata2); end
        tick();
    endtask

    task automatic test_reset_mid();
        apply(1'b1, 1'b1, 5'd9, 32'h1, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        apply(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0);
        total++;
        if (rdata1 !== 32'h1) begin bad++; $display("FAIL mid_pre got=%h want=1", rdata1); end
        tick();
        apply(1'b0, 1'b1, 5'd9, 32'h2, 1'b1, 5'd9, 1'b1, 5'd9);
        total++;
        if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
            bad++; $display("FAIL mid_during got=%h/%h want=0", rdata1, rdata2);
        end
        tick();
        apply(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd31);
        total++;
        if (rdata1 !== 32'h0) begin bad++; $display("FAIL mid_r9 got=%h want=0", rdata1); end
        total++;
        if (rdata2 !== 32'h0) begin bad++; $display("FAIL mid_r31 got=%h want=0", rdata2); end
        tick();
    endtask

    task automatic test_random();
        logic [4:0] a1;
        logic [4:0] a2;
        logic [4:0] wa;
        for (int c = 0; c < 400; c++) begin
            wa = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            apply(($urandom_range(0, 19) != 0), 1'($urandom), wa, $urandom,
                  ($urandom_range(0, 4) != 0), a1, ($urandom_range(0, 4) != 0), a2);
            total++;
            if (rdata1 !== exp1) begin
                bad++; $display("FAIL rand_rd1 cyc%0d a=%0d got=%h want=%h", c, raddr1, rdata1, exp1);
            end
            total++;
            if (rdata2 !== exp2) begin
                bad++; $display("FAIL rand_rd2 cyc%0d a=%0d got=%h want=%h", c, raddr2, rdata2, exp2);
            end
            tick();
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_r0();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
